// File: rtl/ultrasonic_ranger_mc.sv
// ultrasonic_ranger_mc
// Multi-channel HC-SR04-style ultrasonic ranger. Sensors are served
// round-robin: trigger pulse, echo width measured in microseconds, width
// converted to centimetres (58 us per cm), one result published per
// measurement with a timeout flag and a per-channel proximity flag.
//
// Ports:
//   clk      system clock
//   rst      synchronous reset, active low
//   enable   run measurement cycles (sampled only while idle)
//   echo     asynchronous echo lines, one per sensor
//   trig     trigger lines, at most one high at a time
//   dist_cm  last result distance (all ones on timeout), held
//   ch_idx   channel of the last result
//   valid    one-clock pulse when dist_cm/ch_idx/timeout update
//   timeout  last result was a timeout, held with dist_cm
//   near     per channel: last result closer than NEAR_CM and not a timeout
module ultrasonic_ranger_mc #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned N_CH       = 2,
    parameter int unsigned TRIG_US    = 10,
    parameter int unsigned TIMEOUT_US = 30000,
    parameter int unsigned PERIOD_US  = 60000,
    parameter int unsigned DIST_W     = 9,
    parameter int unsigned NEAR_CM    = 20,
    localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [N_CH-1:0]   echo,
    output logic [N_CH-1:0]   trig,
    output logic [DIST_W-1:0] dist_cm,
    output logic [CH_W-1:0]   ch_idx,
    output logic              valid,
    output logic              timeout,
    output logic [N_CH-1:0]   near
);

    localparam int unsigned DIV   = CLK_HZ / 1000000;
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PER_W = $clog2(PERIOD_US + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_US + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [PER_W-1:0]  TRIG_LAST = PER_W'(TRIG_US - 1);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_US - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_US - 1);
    localparam logic [DIST_W-1:0] CM_MAX    = '1;
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(N_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_LOW,
        S_WAIT_RISE,
        S_MEAS,
        S_GAP
    } state_t;

    // Microsecond tick divider
    logic [DIV_W-1:0] div_cnt;
    logic             us_tick;

    assign us_tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (us_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Echo synchronizers (all channels, only the selected one is used)
    logic [N_CH-1:0] echo_m;
    logic [N_CH-1:0] echo_s;

    always_ff @(posedge clk) begin
        if (!rst) begin
            echo_m <= '0;
            echo_s <= '0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
        end
    end

    state_t            state;
    logic [CH_W-1:0]   ch;
    logic [PER_W-1:0]  per_tmr;
    logic [TO_W-1:0]   echo_tmr;
    logic [5:0]        sub_cnt;
    logic [DIST_W-1:0] cm;
    logic              echo_sel;

    assign echo_sel = echo_s[ch];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            ch       <= '0;
            per_tmr  <= '0;
            echo_tmr <= '0;
            sub_cnt  <= '0;
            cm       <= '0;
            trig     <= '0;
            dist_cm  <= '0;
            ch_idx   <= '0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
            near     <= '0;
        end else begin
            valid <= 1'b0;
            if (us_tick) begin
                case (state)
                    S_IDLE: begin
                        if (enable) begin
                            state    <= S_TRIG;
                            per_tmr  <= '0;
                            echo_tmr <= '0;
                            trig     <= N_CH'(1) << ch;
                        end
                    end

                    // The period timer doubles as the trigger-width counter.
                    S_TRIG: begin
                        per_tmr <= per_tmr + PER_W'(1);
                        if (per_tmr == TRIG_LAST) begin
                            trig  <= '0;
                            state <= S_WAIT_LOW;
                        end
                    end

                    // Echo timer covers all three echo phases; timeout wins
                    // over any echo event on the same tick.
                    S_WAIT_LOW, S_WAIT_RISE, S_MEAS: begin
                        per_tmr  <= per_tmr + PER_W'(1);
                        echo_tmr <= echo_tmr + TO_W'(1);
                        if (echo_tmr == TO_LAST) begin
                            valid    <= 1'b1;
                            ch_idx   <= ch;
                            dist_cm  <= '1;
                            timeout  <= 1'b1;
                            near[ch] <= 1'b0;
                            state    <= S_GAP;
                        end else if (state == S_WAIT_LOW) begin
                            if (!echo_sel) begin
                                state <= S_WAIT_RISE;
                            end
                        end else if (state == S_WAIT_RISE) begin
                            // The tick that sees the rise is the first counted microsecond.
                            if (echo_sel) begin
                                state   <= S_MEAS;
                                sub_cnt <= 6'd1;
                                cm      <= '0;
                            end
                        end else if (echo_sel) begin
                            if (sub_cnt == 6'd57) begin
                                sub_cnt <= '0;
                                if (cm != CM_MAX) begin
                                    cm <= cm + DIST_W'(1);
                                end
                            end else begin
                                sub_cnt <= sub_cnt + 6'd1;
                            end
                        end else begin
                            valid    <= 1'b1;
                            ch_idx   <= ch;
                            dist_cm  <= cm;
                            timeout  <= 1'b0;
                            near[ch] <= (32'(cm) < NEAR_CM);
                            state    <= S_GAP;
                        end
                    end

                    S_GAP: begin
                        per_tmr <= per_tmr + PER_W'(1);
                        if (per_tmr == PER_LAST) begin
                            ch    <= (ch == CH_LAST) ? '0 : ch + CH_W'(1);
                            state <= S_IDLE;
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ultrasonic_ranger_mc.sv
// Testbench for ultrasonic_ranger_mc: two channels, 2 clocks per microsecond,
// shortened timeout/period so the whole run stays small.
module tb_ultrasonic_ranger_mc;

    localparam int CLK_HZ     = 2000000;
    localparam int DIV        = 2;
    localparam int N_CH       = 2;
    localparam int TRIG_US    = 10;
    localparam int TIMEOUT_US = 2400;
    localparam int PERIOD_US  = 2450;
    localparam int DIST_W     = 5;
    localparam int NEAR_CM    = 20;
    localparam int SAT        = (1 << DIST_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable = 1'b0;
    logic [N_CH-1:0]   echo = '0;
    logic [N_CH-1:0]   trig;
    logic [DIST_W-1:0] dist_cm;
    logic [0:0]        ch_idx;
    logic              valid;
    logic              timeout;
    logic [N_CH-1:0]   near;

    always #5 clk = ~clk;

    ultrasonic_ranger_mc #(
        .CLK_HZ    (CLK_HZ),
        .N_CH      (N_CH),
        .TRIG_US   (TRIG_US),
        .TIMEOUT_US(TIMEOUT_US),
        .PERIOD_US (PERIOD_US),
        .DIST_W    (DIST_W),
        .NEAR_CM   (NEAR_CM)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .echo   (echo),
        .trig   (trig),
        .dist_cm(dist_cm),
        .ch_idx (ch_idx),
        .valid  (valid),
        .timeout(timeout),
        .near   (near)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor: cycle counter, trigger edges, result capture, invariants
    int unsigned       cyc = 0;
    logic [N_CH-1:0]   trig_q = '0;
    logic              valid_q = 1'b0;
    int unsigned       rise_cnt = 0, fall_cnt = 0, valid_cnt = 0;
    int unsigned       rise_cyc = 0, prev_rise_cyc = 0, fall_cyc = 0, valid_cyc = 0;
    int                rise_ch = 0;
    int                v_dist = 0, v_to = 0, v_ch = 0;
    logic [N_CH-1:0]   v_near = '0;
    int unsigned       onehot_err = 0, pulse_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if ($countones(trig) > 1) onehot_err++;
        if (trig != '0 && trig_q == '0) begin
            prev_rise_cyc = rise_cyc;
            rise_cyc      = cyc;
            rise_cnt++;
            for (int i = 0; i < N_CH; i++) if (trig[i]) rise_ch = i;
        end
        if (trig == '0 && trig_q != '0) begin
            fall_cyc = cyc;
            fall_cnt++;
        end
        if (valid) begin
            if (valid_q) pulse_err++;
            valid_cnt++;
            valid_cyc = cyc;
            v_dist    = int'(dist_cm);
            v_to      = int'(timeout);
            v_ch      = int'(ch_idx);
            v_near    = near;
        end
        valid_q = valid;
        trig_q  = trig;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Reference: the measured width in whole centimetres, saturated; a
    // missing/stuck echo or one running past the timeout yields all ones.
    function automatic void model(input int mode, input int d, input int w,
                                  output int e_dist, output int e_to, output int e_near);
        if (mode != 0 || d + w >= TIMEOUT_US) begin
            e_dist = SAT;
            e_to   = 1;
            e_near = 0;
        end else begin
            e_dist = (w / 58 > SAT) ? SAT : w / 58;
            e_to   = 0;
            e_near = (e_dist < NEAR_CM) ? 1 : 0;
        end
    endfunction

    logic [N_CH-1:0] near_m = '0;
    int              next_ch = 0;

    task automatic wait_rise(input string tag, output bit ok);
        int unsigned rc, t0;
        rc = rise_cnt;
        t0 = cyc;
        while (rise_cnt == rc && (cyc - t0) < (PERIOD_US + 100) * DIV) @(posedge clk);
        ok = (rise_cnt != rc);
        chk({tag, "_trig_start"}, int'(ok), 1);
    endtask

    // mode 0: echo pulse of w us starting d us after trig fall
    // mode 1: echo never rises; mode 2: echo stuck high from trig start
    task automatic run_meas(input string tag, input int mode, input int d, input int w,
                            input int e_dist, input int e_to, input int e_near,
                            input bit chk_sp, input bit drop_en);
        int unsigned fc, vc, t0;
        int          ch;
        bit          ok;
        wait_rise(tag, ok);
        if (!ok) return;
        ch = next_ch;
        fc = fall_cnt;
        chk({tag, "_trig_ch"}, rise_ch, ch);
        if (chk_sp) chk_rng({tag, "_spacing"}, int'(rise_cyc - prev_rise_cyc),
                            PERIOD_US * DIV, (PERIOD_US + 2) * DIV);
        #1;
        if (mode == 2) echo[ch] = 1'b1;
        t0 = cyc;
        while (fall_cnt == fc && (cyc - t0) < (TRIG_US + 20) * DIV) @(posedge clk);
        chk({tag, "_trig_end"}, int'(fall_cnt != fc), 1);
        if (fall_cnt == fc) return;
        chk_rng({tag, "_trig_width"}, int'(fall_cyc - rise_cyc), (TRIG_US - 1) * DIV, (TRIG_US + 1) * DIV);
        #1;
        if (drop_en) enable = 1'b0;
        vc = valid_cnt;
        if (mode == 0) begin
            repeat (d * DIV) @(posedge clk);
            #1 echo[ch] = 1'b1;
            repeat (w * DIV) @(posedge clk);
            #1 echo[ch] = 1'b0;
        end
        t0 = cyc;
        while (valid_cnt == vc && (cyc - t0) < (TIMEOUT_US + 100) * DIV) @(posedge clk);
        #1 echo[ch] = 1'b0;
        chk({tag, "_valid"}, int'(valid_cnt != vc), 1);
        if (valid_cnt == vc) return;
        near_m[ch] = e_near[0];
        chk({tag, "_dist"}, v_dist, e_dist);
        chk({tag, "_timeout"}, v_to, e_to);
        chk({tag, "_ch_idx"}, v_ch, ch);
        chk({tag, "_near"}, int'(v_near), int'(near_m));
        if (mode != 0)
            chk_rng({tag, "_to_time"}, int'(valid_cyc - fall_cyc),
                    (TIMEOUT_US - 1) * DIV, (TIMEOUT_US + 1) * DIV);
        next_ch = (ch + 1) % N_CH;
    endtask

    typedef struct {
        int mode;
        int delay_us;
        int width_us;
        int exp_dist;
        int exp_to;
        int exp_near;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bit          ok;
        int unsigned rc;
        int          m, d, w, ed, et, en;

        vecs[0] = '{0, 100,  580, 10, 0, 1};   // ch0
        vecs[1] = '{0, 100, 1450, 25, 0, 0};   // ch1
        vecs[2] = '{0, 100, 1160, 20, 0, 0};   // ch0: exactly 20 cm is not near
        vecs[3] = '{0,  60, 1102, 19, 0, 1};   // ch1
        vecs[4] = '{1,   0,    0, SAT, 1, 0};  // ch0: no echo
        vecs[5] = '{2,   0,    0, SAT, 1, 0};  // ch1: stuck high
        vecs[6] = '{0,  40, 2200, SAT, 0, 0};  // ch0: saturates

        // Reset state
        repeat (4) @(posedge clk);
        #1;
        chk("rst_trig", int'(trig), 0);
        chk("rst_dist", int'(dist_cm), 0);
        chk("rst_ch_idx", int'(ch_idx), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_near", int'(near), 0);
        rst    = 1'b1;
        enable = 1'b1;

        foreach (vecs[i])
            run_meas($sformatf("vec%0d", i), vecs[i].mode, vecs[i].delay_us, vecs[i].width_us,
                     vecs[i].exp_dist, vecs[i].exp_to, vecs[i].exp_near, i != 0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            m = ($urandom_range(4, 0) == 0) ? 1 : 0;
            d = $urandom_range(80, 20);
            w = $urandom_range(TIMEOUT_US - 60 - d, 60);
            model(m, d, w, ed, et, en);
            run_meas($sformatf("rnd%0d", i), m, d, w, ed, et, en, 1'b1, 1'b0);
        end

        // Reset in the middle of a ch1 echo measurement
        wait_rise("abort", ok);
        chk("abort_ch", rise_ch, next_ch);
        repeat ((TRIG_US + 40) * DIV) @(posedge clk);
        #1 echo[next_ch] = 1'b1;
        repeat (200 * DIV) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_trig", int'(trig), 0);
        chk("abort_dist", int'(dist_cm), 0);
        chk("abort_ch_idx", int'(ch_idx), 0);
        chk("abort_valid", int'(valid), 0);
        chk("abort_timeout", int'(timeout), 0);
        chk("abort_near", int'(near), 0);
        echo   = '0;
        near_m = '0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;

        // Fresh cycle starts on ch0; reset during its trigger drops trig
        wait_rise("rst_trg", ok);
        chk("rst_trg_ch", rise_ch, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_trg_drop", int'(trig), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        next_ch = 0;

        run_meas("post_rst", 0, 100, 580, 10, 0, 1, 1'b0, 1'b0);
        run_meas("en_drop", 0, 80, 1160, 20, 0, 0, 1'b1, 1'b1);

        rc = rise_cnt;
        repeat ((2 * PERIOD_US + 100) * DIV) @(posedge clk);
        chk("no_retrigger", int'(rise_cnt - rc), 0);

        chk("trig_onehot", int'(onehot_err), 0);
        chk("valid_pulse", int'(pulse_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ultrasonic_ranger_mc.md
Name: ultrasonic_ranger_mc

Overview:
Multi-channel HC-SR04-style ultrasonic ranger. It is the parametrised successor to the single-channel trigger/echo block. It time-multiplexes N_CH sensors round-robin: issues a trigger pulse, measures the echo width in microseconds, and converts the width to centimetres. It reports one result per measurement with a timeout flag and a per-channel proximity flag. It sits between the sensor pins and the control/display logic.

Parameters:
CLK_HZ, 50000000, system clock frequency; must be a multiple of 1000000
N_CH, 2, number of sensor channels (1..8)
TRIG_US, 10, trigger pulse width in µs
TIMEOUT_US, 30000, maximum wait for an echo edge or echo width, in µs
PERIOD_US, 60000, minimum spacing between trigger starts, in µs (must exceed TRIG_US+2*TIMEOUT_US/2)
DIST_W, 9, width of the distance output; saturates at 2^DIST_W-1
NEAR_CM, 20, proximity threshold in cm

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-low
enable  input  1  1 = run measurement cycles; sampled only in IDLE
echo  input  N_CH  asynchronous echo lines from the sensors
trig  output  N_CH  trigger lines; at most one bit high at a time
dist_cm  output  DIST_W  last result distance, held until the next result
ch_idx  output  clog2(N_CH) (min 1)  channel of the last result
valid  output  1  one-cycle pulse when dist_cm/ch_idx/timeout update
timeout  output  1  last result was a timeout; held with dist_cm
near  output  N_CH  per channel: 1 if that channel's last result < NEAR_CM and not a timeout

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; channel pointer 0; tick divider 0; all timers 0; trig=0, dist_cm=0, ch_idx=0, valid=0, timeout=0, near=0. Reset mid-measurement aborts immediately, and trig drops on the next edge.
- Tick: free-running divider with period CLK_HZ/1000000 clocks. It produces a one-clock pulse us_tick. All timers advance only on us_tick.
- Echo: each bit is passed through a 2-FF synchronizer. Only the selected channel is observed.
- FSM (transitions on us_tick only):
  IDLE: if enable=1, go to TRIG, clear period timer and echo timer.
  TRIG: trig[ch]=1 for exactly TRIG_US ticks, then trig=0 and go to WAIT_LOW.
  WAIT_LOW: echo must be seen low; once low, go to WAIT_RISE.
  WAIT_RISE: on echo=1, go to MEAS and clear the µs counter and cm counter.
  MEAS: each tick with echo=1 increments the µs counter. Every 58th µs increments cm (sub-counter 0..57). cm saturates at 2^DIST_W-1. When echo=0, publish the result and go to GAP.
  Timeout: the echo timer runs from trig fall through WAIT_LOW, WAIT_RISE and MEAS. When it reaches TIMEOUT_US, publish a timeout result and go to GAP. A stuck-high echo therefore times out.
  GAP: wait until the period timer (started at TRIG entry) reaches PERIOD_US. Then advance the channel (N_CH-1 wraps to 0) and go to IDLE.
- Publish (same clock as the transition out of MEAS/timeout):
  - valid=1 for one clock; ch_idx=ch.
  - Normal result: dist_cm=cm, timeout=0, near[ch]=(cm<NEAR_CM).
  - Timeout result: dist_cm=all ones, timeout=1, near[ch]=0.
  - Other near bits are unchanged.
- enable=0 during a measurement: the current cycle completes, including GAP. The FSM then stays in IDLE, and the channel pointer has already advanced.
- Latency: echo edges register 2 clocks + up to 1 tick late. Tolerance is ±1 µs on measured width.

Test Plan:
- N_CH=1, enable=1, echo high 580 µs starting 100 µs after trig fall -> trig high 10 µs (±1); valid pulse; dist_cm=10, timeout=0, near[0]=1, ch_idx=0.
- Echo high 1160 µs -> dist_cm=20, near=0. Echo high 1102 µs -> dist_cm=19, near=1 (strict less-than).
- Echo never rises -> valid exactly 30000 µs (±1) after trig fall; dist_cm=511, timeout=1, near=0. Stuck-high echo gives the same result.
- Echo high 29900 µs -> dist_cm=511 (saturated), timeout=0.
- N_CH=2, echo0=580 µs, echo1=2900 µs -> trig0 then trig1 starts 60000 µs apart; results ch0: 10, ch1: 50; near=2'b01; trig never both high; third cycle returns to ch0.
- Assert rst=0 mid-MEAS -> next edge trig=0, outputs 0. Release rst -> a fresh cycle on ch0 gives a correct result; enable=0 mid-cycle -> the cycle finishes and no further trig occurs.
